// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: serial configuration loader for a PAL fuse array.
// Hunts for the 0xA5 sync byte in a serial, MSB-first bit stream and then
// assembles NUM_WORDS words of WORD_W bits. Each finished word is presented
// to the fuse array as a one-cycle write strobe with its word index.
// Optional feature macro: PAL_CFG_CRC_EN. When defined, a CRC-8 (poly 0x07,
// init 0x00) over the data bits is checked against 8 trailing bits, and the
// frame ends in DONE or ERR. When undefined, the frame ends in DONE directly
// after the last word and cfg_err is tied low.
module pal_cfg_loader #(
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 32,
    localparam int ADDR_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_bit_valid,
    input  logic              cfg_bit,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef PAL_CFG_CRC_EN
    localparam logic [2:0] ST_CHECK = 3'd3;
`endif
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;

    localparam logic [7:0]        SYNC_WORD = 8'hA5;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic [2:0]        state;
    logic [7:0]        sync_win;
    logic [WORD_W-1:0] word_sr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-1:0] word_idx;

`ifdef PAL_CFG_CRC_EN
    localparam logic [7:0] CRC_POLY = 8'h07;

    logic [7:0] crc;
    logic [7:0] chk_sr;
    logic [2:0] chk_cnt;

    // One MSB-first CRC-8 step: the incoming bit is folded into the top bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction
`endif

    // Shift one bit into the bottom of a word-wide register (MSB arrives first).
    function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] s, input logic b);
        return WORD_W'({s, b});
    endfunction

    // Shift one bit into the bottom of a byte-wide register.
    function automatic logic [7:0] shift_byte(input logic [7:0] s, input logic b);
        return {s[6:0], b};
    endfunction

    // Frame state machine, bit assembly, write strobe and (optional) CRC check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sync_win <= '0;
            word_sr  <= '0;
            bit_cnt  <= '0;
            word_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
`ifdef PAL_CFG_CRC_EN
            crc      <= '0;
            chk_sr   <= '0;
            chk_cnt  <= '0;
`endif
        end else begin
            // The strobe is a single-cycle pulse; it is only raised below.
            wr_en <= 1'b0;
            if (!cfg_en) begin
                // Dropping the enable aborts any load; wr_addr/wr_data keep
                // their last values so the fuse array sees a stable bus.
                state    <= ST_IDLE;
                sync_win <= '0;
                word_sr  <= '0;
                bit_cnt  <= '0;
                word_idx <= '0;
`ifdef PAL_CFG_CRC_EN
                crc      <= '0;
                chk_sr   <= '0;
                chk_cnt  <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        if (cfg_bit_valid) begin
                            // Sliding window: garbage ahead of the sync byte
                            // simply falls off the top.
                            if (shift_byte(sync_win, cfg_bit) == SYNC_WORD) begin
                                state    <= ST_DATA;
                                sync_win <= '0;
                            end else begin
                                sync_win <= shift_byte(sync_win, cfg_bit);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (cfg_bit_valid) begin
`ifdef PAL_CFG_CRC_EN
                            crc <= crc8_step(crc, cfg_bit);
`endif
                            if (bit_cnt == LAST_BIT) begin
                                wr_en   <= 1'b1;
                                wr_addr <= word_idx;
                                wr_data <= shift_word(word_sr, cfg_bit);
                                word_sr <= '0;
                                bit_cnt <= '0;
                                // The index stops at the last word instead of
                                // wrapping; the frame moves on instead.
                                if (word_idx == LAST_ADDR) begin
`ifdef PAL_CFG_CRC_EN
                                    state <= ST_CHECK;
`else
                                    state <= ST_DONE;
`endif
                                end else begin
                                    word_idx <= word_idx + ADDR_W'(1);
                                end
                            end else begin
                                word_sr <= shift_word(word_sr, cfg_bit);
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef PAL_CFG_CRC_EN
                    ST_CHECK: begin
                        if (cfg_bit_valid) begin
                            if (chk_cnt == 3'd7) begin
                                state   <= (shift_byte(chk_sr, cfg_bit) == crc) ? ST_DONE : ST_ERR;
                                chk_sr  <= '0;
                                chk_cnt <= '0;
                            end else begin
                                chk_sr  <= shift_byte(chk_sr, cfg_bit);
                                chk_cnt <= chk_cnt + 3'd1;
                            end
                        end
                    end
`endif
                    ST_DONE, ST_ERR: begin
                        // Terminal until the enable is dropped.
                        state <= state;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy     = 1'b0;
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        case (state)
            ST_SYNC:  busy = 1'b1;
            ST_DATA:  busy = 1'b1;
`ifdef PAL_CFG_CRC_EN
            ST_CHECK: busy = 1'b1;
            ST_ERR:   cfg_err = 1'b1;
`endif
            ST_DONE:  cfg_done = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader (default WORD_W=8, NUM_WORDS=32).
// Builds with or without PAL_CFG_CRC_EN; CRC frames are only sent when defined.
module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_en;
    logic       cfg_bit_valid;
    logic       cfg_bit;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;

    int n_checks = 0;
    int n_errors = 0;
    int wr_pulses = 0;
    int base;

    pal_cfg_loader dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err)
    );

    always #5 clk = ~clk;

    // Count every cycle the write strobe is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en) wr_pulses <= wr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        cfg_bit_valid = 1'b1;
        cfg_bit       = b;
        tick();
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
        repeat (gap) tick();
    endtask

    // Send one word; the strobe for it must be visible right after its last bit.
    task automatic send_word(input logic [7:0] w, input int gap, input logic [4:0] exp_addr);
        for (int i = 7; i >= 0; i--) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = w[i];
            tick();
            cfg_bit_valid = 1'b0;
            cfg_bit       = 1'b0;
            if (i == 0) check($sformatf("wr%0d", exp_addr), {18'd0, wr_en, wr_addr, wr_data}, {18'd0, 1'b1, exp_addr, w});
            repeat (gap) tick();
        end
    endtask

    task automatic send_preamble(input int gap);
        logic [7:0] pre;
        pre = 8'hA5;
        send_bit(1'b1, gap);
        send_bit(1'b1, gap);
        send_bit(1'b0, gap);
        for (int i = 7; i >= 0; i--) send_bit(pre[i], gap);
    endtask

`ifdef PAL_CFG_CRC_EN
    // Byte-at-a-time CRC-8/0x07 reference.
    function automatic logic [7:0] crc_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction
`endif

    // Full frame: garbage 1,1,0, sync, 32 words of addr^0x3C, then CRC if built in.
    task automatic send_frame(input int gap, input bit bad_crc);
`ifdef PAL_CFG_CRC_EN
        logic [7:0] crc;
        crc = 8'h00;
`endif
        send_preamble(gap);
        for (int a = 0; a < 32; a++) begin
            send_word(8'(a) ^ 8'h3C, gap, 5'(a));
`ifdef PAL_CFG_CRC_EN
            crc = crc_byte(crc, 8'(a) ^ 8'h3C);
`endif
        end
`ifdef PAL_CFG_CRC_EN
        check("busy_in_check", {31'd0, busy}, 32'd1);
        if (bad_crc) crc = crc ^ 8'h01;
        for (int i = 7; i >= 0; i--) send_bit(crc[i], gap);
`else
        if (bad_crc) check("bad_crc_unsupported", 32'd0, 32'd0 + 32'(bad_crc));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_en = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;

        // Reset with random inputs.
        repeat (2) begin
            cfg_en = 1'($urandom); cfg_bit_valid = 1'($urandom); cfg_bit = 1'($urandom);
            tick();
        end
        check("rst_outputs", {16'd0, wr_en, wr_addr, wr_data, busy, cfg_done, cfg_err},
              {16'd0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0; cfg_en = 1'b0; cfg_bit_valid = 1'b1; cfg_bit = 1'b1;
        repeat (3) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);
        cfg_bit_valid = 1'b0; cfg_bit = 1'b0;

        // Nominal frame.
        cfg_en = 1'b1;
        tick();
        check("sync_busy", {31'd0, busy}, 32'd1);
        base = wr_pulses;
        send_frame(0, 1'b0);
        check("done_flags", {29'd0, busy, cfg_done, cfg_err}, {29'd0, 3'b010});
        tick();
        check("wr_hold", {18'd0, wr_en, wr_addr, wr_data}, {18'd0, 1'b0, 5'd31, 8'h23});
        check("pulses_full", 32'(wr_pulses - base), 32'd32);
        repeat (3) tick();
        check("done_held", {30'd0, cfg_done, busy}, {30'd0, 2'b10});
        cfg_en = 1'b0;
        tick();
        check("done_clear", {29'd0, busy, cfg_done, cfg_err}, 32'd0);

`ifdef PAL_CFG_CRC_EN
        // Corrupted CRC.
        cfg_en = 1'b1;
        tick();
        base = wr_pulses;
        send_frame(0, 1'b1);
        check("err_flags", {29'd0, busy, cfg_done, cfg_err}, {29'd0, 3'b001});
        tick();
        check("pulses_bad", 32'(wr_pulses - base), 32'd32);
        cfg_en = 1'b0;
        tick();
        check("err_clear", {29'd0, busy, cfg_done, cfg_err}, 32'd0);
`endif

        // Abort after word 10, then a fresh frame restarting at address 0.
        cfg_en = 1'b1;
        tick();
        base = wr_pulses;
        send_preamble(0);
        for (int a = 0; a <= 10; a++) send_word(8'(a) ^ 8'h3C, 0, 5'(a));
        cfg_en = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 16; i++) send_bit(1'($urandom), 0);
        check("abort_pulses", 32'(wr_pulses - base), 32'd11);
        cfg_en = 1'b1;
        tick();
        base = wr_pulses;
        send_frame(0, 1'b0);
        check("restart_done", {29'd0, busy, cfg_done, cfg_err}, {29'd0, 3'b010});
        tick();
        check("restart_pulses", 32'(wr_pulses - base), 32'd32);
        cfg_en = 1'b0;
        tick();

        // Valid bits only every third cycle.
        cfg_en = 1'b1;
        tick();
        base = wr_pulses;
        send_frame(2, 1'b0);
        check("gap_done", {29'd0, busy, cfg_done, cfg_err}, {29'd0, 3'b010});
        check("gap_pulses", 32'(wr_pulses - base), 32'd32);
        cfg_en = 1'b0;
        tick();

        // Reset on the edge that samples the last bit of word 5.
        cfg_en = 1'b1;
        tick();
        base = wr_pulses;
        send_preamble(0);
        for (int a = 0; a < 5; a++) send_word(8'(a) ^ 8'h3C, 0, 5'(a));
        begin
            logic [7:0] w5;
            w5 = 8'h05 ^ 8'h3C;
            for (int i = 7; i >= 1; i--) send_bit(w5[i], 0);
            cfg_bit_valid = 1'b1; cfg_bit = w5[0]; rst = 1'b1;
            tick();
            cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
        end
        check("rst_mid_wr", {30'd0, wr_en, busy}, 32'd0);
        check("rst_mid_bus", {19'd0, wr_addr, wr_data}, 32'd0);
        rst = 1'b0; cfg_en = 1'b0;
        tick();
        check("rst_mid_pulses", 32'(wr_pulses - base), 32'd5);
        check("rst_mid_idle", {29'd0, busy, cfg_done, cfg_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
